drv_c2sif_gpio: RTL



---
 rtl/drv_c2sif_gpio.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/drv_c2sif_gpio.sv
// c2sif GPIO endpoint: drives a WIDTH-bit din bus and samples a synchronised dout bus
// on request (write/read/set/clear/toggle, one-clock pulse, wait-for-condition with timeout).
module drv_c2sif_gpio #(
  parameter int               ID          = 0,
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] INIT        = '0,
  parameter int               SYNC_STAGES = 2,
  parameter int               TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [7:0]       id,
  input  logic [3:0]       fn,
  input  logic [WIDTH-1:0] wdata,
  output logic             ack,
  output logic [7:0]       ret,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] dout,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SKIP  = 3'd1;
  localparam logic [2:0] EXEC  = 3'd2;
  localparam logic [2:0] PULSE = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] ACK   = 3'd5;

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [7:0]    MY_ID    = ID[7:0];

  // Handshake: 4-phase. A request starts on a rising req; ack rises once the
  // operation is done and stays high (ret/rdata stable) until req is seen low.

  logic [2:0]       state_q, state_d;
  logic             req_q;
  logic [3:0]       fn_q, fn_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] saved_q, saved_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic [7:0]       ret_q, ret_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] dout_s;
  logic             rise;

  assign dout_s = sync_q[SYNC_STAGES-1];
  assign rise   = req & ~req_q;

  always_comb begin
    state_d = state_q;
    fn_d    = fn_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    ret_d   = ret_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (rise && id == MY_ID) begin
          fn_d    = fn;
          wdata_d = wdata;
          state_d = EXEC;
        end else if (rise) begin
          state_d = SKIP;
        end
      end
      SKIP: if (!req) state_d = IDLE;
      EXEC: begin
        rdata_d = '0;
        ret_d   = 8'd0;
        ack_d   = 1'b1;
        state_d = ACK;
        case (fn_q)
          4'd0: din_d = wdata_q;
          4'd1: rdata_d = din_q;
          4'd2: rdata_d = dout_s;
          4'd3: din_d = din_q | wdata_q;
          4'd4: din_d = din_q & ~wdata_q;
          4'd5: din_d = din_q ^ wdata_q;
          4'd6: begin
            din_d   = din_q ^ wdata_q;
            saved_d = din_q;
            ack_d   = 1'b0;
            state_d = PULSE;
          end
          4'd7: begin
            cnt_d   = '0;
            ack_d   = 1'b0;
            state_d = WAIT;
          end
          default: ret_d = 8'd1;
        endcase
      end
      PULSE: begin
        din_d   = saved_q;
        ret_d   = 8'd0;
        ack_d   = 1'b1;
        state_d = ACK;
      end
      WAIT: begin
        if ((dout_s & wdata_q) != '0) begin
          rdata_d = dout_s;
          ret_d   = 8'd0;
          ack_d   = 1'b1;
          state_d = ACK;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = dout_s;
          ret_d   = 8'd2;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK: begin
        if (!req) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b1;  // a req held through reset must not look like a new rise
      fn_q    <= '0;
      wdata_q <= '0;
      din_q   <= INIT;
      saved_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      ret_q   <= '0;
      rdata_q <= '0;
      sync_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      fn_q      <= fn_d;
      wdata_q   <= wdata_d;
      din_q     <= din_d;
      saved_q   <= saved_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      ret_q     <= ret_d;
      rdata_q   <= rdata_d;
      sync_q[0] <= dout;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ack       = ack_q;
  assign ret       = ret_q;
  assign rdata     = rdata_q;
  assign din       = din_q;
  assign dbg_state = state_q;

endmodule
